dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory target serving the memory stage's load/store requests over a valid/ready request channel and a valid/ready response channel.
- Owns a word-addressed RAM, handles RV32I sub-word access (funct3-encoded size/sign), applies a configurable wait-state latency and flags misaligned or out-of-range accesses.
- Sits between the memory stage and the writeback path. Exactly one request is outstanding at a time.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the array (power of two)
- LATENCY, 2, cycles from request accept to rsp_valid assertion (legal range 1..15)
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_funct3  input  3  RV32I load/store funct3 (size/sign)
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-aligned
- rsp_valid  output  1  response present
- rsp_ready  input  1  consumer accepts response
- rsp_rdata  output  32  load data, extended per funct3; 0 for stores and errors
- rsp_err  output  1  misaligned, out-of-range or illegal funct3

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous, active-high (reset). Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter=0. RAM contents are not cleared.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid, the request is accepted at that edge and addr/funct3/write are latched. Next state is WAIT if LATENCY>1, else RESP. Counter loads LATENCY-1.
  - WAIT: req_ready=0. Counter decrements each cycle. When the counter reaches 1, go to RESP.
  - RESP: rsp_valid=1. rsp_rdata and rsp_err are stable until the handshake. On rsp_ready, go to IDLE.
- Latency: a request accepted at edge N sees rsp_valid high from the cycle after edge N+LATENCY-1, i.e. LATENCY cycles after acceptance.
- Back-to-back: req_ready is low in RESP. The next request can be accepted no earlier than the cycle after the rsp handshake. There is no combinational path from rsp_ready to req_ready.
- Store commit: the RAM write happens at the accept edge, with byte lanes chosen by funct3 and addr[1:0]. A following load therefore always observes it.
- Load data: captured into the rsp_rdata register on entry to RESP.
- funct3 handling:
  - 000 LB/SB: byte, sign-extended on load.
  - 001 LH/SH: halfword, sign-extended on load.
  - 010 LW/SW: word.
  - 100 LBU and 101 LHU: zero-extended; loads only.
  - Any other value, and 100/101 on a store, is illegal.
- Errors are detected at accept:
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr < BASE_ADDR or addr >= BASE_ADDR+4*DEPTH_WORDS;
  - illegal funct3.
  - An erroring access writes nothing, returns rsp_rdata=0 and rsp_err=1, with the same latency as a good access.
- Stores respond with rsp_rdata=0 and rsp_err=0.
- Index computation: (addr-BASE_ADDR)>>2, truncated to log2(DEPTH_WORDS) bits after the range check.
- Reset mid-operation: the pending response is dropped and the FSM returns to IDLE. A store already accepted stays committed.
- Request inputs are ignored while req_ready=0.

Decomposition:
- Package pipe_mem_pkg holds:
  - mem_funct3_e enum (LB, LH, LW, LBU, LHU, SB, SH, SW encodings);
  - the resp_state_e enum (IDLE, WAIT, RESP);
  - a helper constant for the word-offset width.
- Sub-module dmem_lane_align is purely combinational. Inputs: funct3, addr[1:0], wdata, and the raw read word. Outputs: 4-bit byte write enable, lane-shifted write data, extended load data, misalign flag.

Test Plan:
- LATENCY=2. SW 0xDEADBEEF @0x10, then LW @0x10 -> rsp_valid 2 cycles after each accept; load returns 0xDEADBEEF, rsp_err=0.
- After the word above: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SB 0x55 @0x11 over 0xDEADBEEF, then LW @0x10 -> 0xDEAD55EF. Only lane 1 is written.
- LW @0x12, SH @0x21, LW @0x400 (DEPTH_WORDS=256), funct3=011 -> each gives rsp_err=1 and rsp_rdata=0. A following LW of the affected words shows them unchanged.
- rsp_ready held low 5 cycles during RESP -> rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0. Releasing rsp_ready gives one handshake, then req_ready=1 the next cycle.
- Reset asserted in WAIT after SW 0x12345678 @0x20 -> next cycle rsp_valid=0 and req_ready=1. A subsequent LW @0x20 -> 0x12345678. With LATENCY=1, rsp_valid appears the cycle after accept.

Source files
------------

// File: rtl/pipe_mem_pkg.sv
// Shared types for the data-memory responder: funct3 encodings, FSM states
// and the byte-offset width within a 32-bit word.
package pipe_mem_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } mem_funct3_e;

  // Stores share the load encodings for the three legal sizes
  localparam mem_funct3_e SB = LB;
  localparam mem_funct3_e SH = LH;
  localparam mem_funct3_e SW = LW;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_e;

  localparam int WORD_OFFSET_W = 2;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for RV32I sub-word loads and stores:
// write enables, replicated store data, extended load data, misalign flag.
module dmem_lane_align
  import pipe_mem_pkg::*;
(
  input  logic [2:0]               funct3,
  input  logic [WORD_OFFSET_W-1:0] byteOffset,
  input  logic [31:0]              wdata,
  input  logic [31:0]              rword,
  output logic [3:0]               byteEn,
  output logic [31:0]              wdataLane,
  output logic [31:0]              loadData,
  output logic                     misaligned
);

  logic [7:0]  selByte;
  logic [15:0] selHalf;

  always_comb begin
    byteEn     = '0;
    wdataLane  = '0;
    loadData   = '0;
    misaligned = 1'b0;
    selByte    = rword[{byteOffset, 3'b000} +: 8];
    selHalf    = rword[{byteOffset[1], 4'b0000} +: 16];

    // Store data is replicated across lanes; byteEn picks the live ones
    case (funct3[1:0])
      2'b00: begin
        byteEn    = 4'b0001 << byteOffset;
        wdataLane = {4{wdata[7:0]}};
      end
      2'b01: begin
        byteEn     = 4'b0011 << {byteOffset[1], 1'b0};
        wdataLane  = {2{wdata[15:0]}};
        misaligned = byteOffset[0];
      end
      2'b10: begin
        byteEn     = 4'b1111;
        wdataLane  = wdata;
        misaligned = |byteOffset;
      end
      default: ;
    endcase

    case (funct3)
      LB:      loadData = {{24{selByte[7]}}, selByte};
      LH:      loadData = {{16{selHalf[15]}}, selHalf};
      LW:      loadData = rword;
      LBU:     loadData = {24'h0, selByte};
      LHU:     loadData = {16'h0, selHalf};
      default: loadData = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target: one outstanding load/store, fixed wait-state latency,
// byte-lane RAM with registered read, error flag for bad accesses.
module dmem_responder
  import pipe_mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

  resp_state_e stateReg, stateNext;
  logic [3:0]  cntReg, cntNext;
  logic        writeReg, errReg;
  logic [2:0]  funct3Reg;
  logic [WORD_OFFSET_W-1:0] offReg;

  logic [32:0] addrDiff;
  logic        outOfRange, illegalF3, reqErr, accept, doWrite, inIdle;
  logic [IDX_W-1:0] wordIdx;
  logic [2:0]  alignF3;
  logic [WORD_OFFSET_W-1:0] alignOff;
  logic [3:0]  byteEn;
  logic [31:0] wdataLane, loadData, rdWord;
  logic        misaligned;

  // A borrow out of the subtraction makes addrDiff exceed SPAN as well
  assign addrDiff   = {1'b0, req_addr} - {1'b0, BASE_ADDR};
  assign outOfRange = addrDiff >= SPAN;
  assign wordIdx    = addrDiff[WORD_OFFSET_W +: IDX_W];

  always_comb begin
    case (req_funct3)
      LB, LH, LW: illegalF3 = 1'b0;
      LBU, LHU:   illegalF3 = req_write;
      default:    illegalF3 = 1'b1;
    endcase
  end

  // One aligner: request fields while idle, latched fields afterwards
  assign inIdle   = (stateReg == IDLE);
  assign alignF3  = inIdle ? req_funct3 : funct3Reg;
  assign alignOff = inIdle ? req_addr[WORD_OFFSET_W-1:0] : offReg;

  dmem_lane_align u_align (
    .funct3     (alignF3),
    .byteOffset (alignOff),
    .wdata      (req_wdata),
    .rword      (rdWord),
    .byteEn     (byteEn),
    .wdataLane  (wdataLane),
    .loadData   (loadData),
    .misaligned (misaligned)
  );

  assign reqErr  = outOfRange | illegalF3 | misaligned;
  assign accept  = inIdle & req_valid & ~reset;
  assign doWrite = accept & req_write & ~reqErr;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] laneMem [DEPTH_WORDS];
    logic [7:0] rdByteReg;

    always_ff @(posedge clk) begin
      if (doWrite && byteEn[gi]) laneMem[wordIdx] <= wdataLane[gi*8 +: 8];
      if (accept) rdByteReg <= laneMem[wordIdx];
    end

    assign rdWord[gi*8 +: 8] = rdByteReg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg  <= IDLE;
      cntReg    <= '0;
      writeReg  <= 1'b0;
      errReg    <= 1'b0;
      funct3Reg <= '0;
      offReg    <= '0;
    end else begin
      stateReg <= stateNext;
      cntReg   <= cntNext;
      if (accept) begin
        writeReg  <= req_write;
        errReg    <= reqErr;
        funct3Reg <= req_funct3;
        offReg    <= req_addr[WORD_OFFSET_W-1:0];
      end
    end
  end

  always_comb begin
    stateNext = stateReg;
    cntNext   = cntReg;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (stateReg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cntNext   = CNT_LOAD;
          stateNext = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cntReg <= 4'd1) begin
          cntNext   = '0;
          stateNext = RESP;
        end else begin
          cntNext = cntReg - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Built only from registers frozen since accept, so stable through RESP
  assign rsp_rdata = (rsp_valid && !errReg && !writeReg) ? loadData : '0;
  assign rsp_err   = rsp_valid & errReg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: scoreboard of expected responses,
// latency/stability checks, error cases, reset mid-flight, LATENCY=1 copy.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid, reqWrite, rspReady, useB;
  logic [2:0]  reqFunct3;
  logic [31:0] reqAddr, reqWdata;

  logic        aReqReady, aRspValid, aRspErr;
  logic [31:0] aRspRdata;
  logic        bReqReady, bRspValid, bRspErr;
  logic [31:0] bRspRdata;

  logic        obsReqReady, obsRspValid, obsRspErr;
  logic [31:0] obsRspRdata;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) u_dutA (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (reqValid & ~useB),
    .req_ready  (aReqReady),
    .req_write  (reqWrite),
    .req_funct3 (reqFunct3),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .rsp_valid  (aRspValid),
    .rsp_ready  (rspReady & ~useB),
    .rsp_rdata  (aRspRdata),
    .rsp_err    (aRspErr)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0)) u_dutB (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (reqValid & useB),
    .req_ready  (bReqReady),
    .req_write  (reqWrite),
    .req_funct3 (reqFunct3),
    .req_addr   (reqAddr),
    .req_wdata  (reqWdata),
    .rsp_valid  (bRspValid),
    .rsp_ready  (rspReady & useB),
    .rsp_rdata  (bRspRdata),
    .rsp_err    (bRspErr)
  );

  assign obsReqReady = useB ? bReqReady : aReqReady;
  assign obsRspValid = useB ? bRspValid : aRspValid;
  assign obsRspErr   = useB ? bRspErr   : aRspErr;
  assign obsRspRdata = useB ? bRspRdata : aRspRdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request/response; hold = cycles rsp_ready stays low inside RESP
  task automatic xact(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] expData,
                      input logic expErr, input int hold);
    int          lat;
    exp_t        e;
    logic [31:0] snapData;
    logic        snapErr;
    sb.push_back(exp_t'{expData, expErr});
    @(negedge clk);
    chk("req_ready_idle", 32'(obsReqReady), 32'd1);
    reqValid = 1'b1; reqWrite = wr; reqFunct3 = f3; reqAddr = addr; reqWdata = wd;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    lat = 1;
    while (obsRspValid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), useB ? 32'd1 : 32'd2);
    chk("req_ready_resp", 32'(obsReqReady), 32'd0);
    snapData = obsRspRdata;
    snapErr  = obsRspErr;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(obsRspValid), 32'd1);
      chk("stall_rdata", obsRspRdata, snapData);
      chk("stall_err", 32'(obsRspErr), 32'(snapErr));
      chk("stall_req_ready", 32'(obsReqReady), 32'd0);
    end
    rspReady = 1'b1;
    e = sb.pop_front();
    chk("rsp_rdata", obsRspRdata, e.data);
    chk("rsp_err", 32'(obsRspErr), 32'(e.err));
    $display("xact wr=%0d f3=%03b addr=%h wd=%h -> rdata=%h err=%0d lat=%0d",
             wr, f3, addr, wd, obsRspRdata, obsRspErr, lat);
    @(posedge clk);
    @(negedge clk);
    rspReady = 1'b0;
    chk("post_rsp_valid", 32'(obsRspValid), 32'd0);
    chk("post_req_ready", 32'(obsReqReady), 32'd1);
  endtask

  initial begin
    reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqFunct3 = 3'b000;
    reqAddr = '0; reqWdata = '0; rspReady = 1'b0; useB = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_req_ready", 32'(obsReqReady), 32'd1);
    chk("reset_rsp_valid", 32'(obsRspValid), 32'd0);
    chk("reset_rsp_rdata", obsRspRdata, 32'd0);
    chk("reset_rsp_err", 32'(obsRspErr), 32'd0);

    // Word store/load and sub-word extraction
    xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    xact(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
    xact(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0, 0);
    xact(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0, 0);
    xact(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 0);

    // Byte store touches lane 1 only
    xact(1'b1, 3'b000, 32'h11, 32'hFFFFFF55, 32'h0, 1'b0, 0);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 0);

    // Reset while the store sits in WAIT: response dropped, store kept
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqFunct3 = 3'b010;
    reqAddr = 32'h20; reqWdata = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    reqValid = 1'b0;
    chk("wait_rsp_valid", 32'(obsRspValid), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_rsp_valid", 32'(obsRspValid), 32'd0);
    chk("midreset_req_ready", 32'(obsReqReady), 32'd1);
    $display("xact reset during store wait: rsp_valid=%0d req_ready=%0d", obsRspValid, obsReqReady);
    xact(1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0, 0);

    // Error cases: misaligned, out of range, illegal funct3
    xact(1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1, 0);
    xact(1'b1, 3'b001, 32'h21, 32'hAAAA, 32'h0, 1'b1, 0);
    xact(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, 1'b1, 0);
    xact(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    xact(1'b1, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    xact(1'b1, 3'b100, 32'h10, 32'h0, 32'h0, 1'b1, 0);
    xact(1'b1, 3'b010, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 0);
    xact(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 0);
    xact(1'b0, 3'b010, 32'h20, 32'h0, 32'h12345678, 1'b0, 0);

    // Upper halfword store, then highest in-range word
    xact(1'b1, 3'b001, 32'h22, 32'h0000ABCD, 32'h0, 1'b0, 0);
    xact(1'b0, 3'b010, 32'h20, 32'h0, 32'hABCD5678, 1'b0, 0);
    xact(1'b1, 3'b010, 32'h3FC, 32'h01020304, 32'h0, 1'b0, 0);
    xact(1'b0, 3'b101, 32'h3FE, 32'h0, 32'h00000102, 1'b0, 0);

    // Consumer stalls for 5 cycles in RESP
    xact(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0, 5);

    // LATENCY=1 instance
    useB = 1'b1;
    xact(1'b1, 3'b010, 32'h08, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    xact(1'b0, 3'b010, 32'h08, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    xact(1'b0, 3'b000, 32'h08, 32'h0, 32'h0000000D, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
